seg7_scan_driver: RTL and testbench

//   Multiplexed N-digit 7-segment display driver. It time-scans DIGITS common-anode digits

---
 rtl/seg7_scan_driver_if.sv | 26 ++
 rtl/seg7_scan_driver.sv | 135 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Board-side bundle for the multiplexed 7-segment driver: numeric inputs in,
// active-low select/segment pins and the frame pulse out.
interface seg7_scan_driver_if #(
    parameter int DIGITS = 6
);
    logic [4*DIGITS-1:0] data_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   en_in;
    logic                hex_mode;
    logic                lz_suppress;
    logic [DIGITS-1:0]   seg_sel;
    logic [7:0]          seg_data;
    logic                frame_done;

    // Producer of the numbers to display (datapath side)
    modport master (
        output data_in, dp_in, en_in, hex_mode, lz_suppress,
        input  seg_sel, seg_data, frame_done
    );

    // The scan driver itself
    modport slave (
        input  data_in, dp_in, en_in, hex_mode, lz_suppress,
        output seg_sel, seg_data, frame_done
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-segment driver. Inputs are captured
// once per frame so a display never tears; each digit slot starts with a short
// all-off window to hide ghosting while the select lines switch.
module seg7_scan_driver #(
    parameter int DIGITS       = 6,
    parameter int SCAN_CYCLES  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic               clk,
    input  logic               rst,
    seg7_scan_driver_if.slave  bus
);
    localparam int CNT_W = $clog2(SCAN_CYCLES);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    if (BLANK_CYCLES >= SCAN_CYCLES || DIGITS < 1 || DIGITS > 8) begin : g_bad_params
        $error("seg7_scan_driver: need DIGITS in 1..8 and BLANK_CYCLES < SCAN_CYCLES");
    end

    // Active-low segment pattern (g..a); codes 10..15 are letters only in hex mode
    function automatic logic [6:0] decode_seg(input logic [3:0] nib, input logic hex);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        if (!hex && nib > 4'h9) begin
            seg = 7'h7F;
        end
        return seg;
    endfunction

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] snap_data;
    logic [DIGITS-1:0]   snap_dp;
    logic [DIGITS-1:0]   snap_en;
    logic                snap_hex;
    logic                snap_lz;

    logic                slot_end;
    logic                frame_end;
    logic                blank;
    logic [3:0]          nib;
    logic                suppress;
    logic                all_zero;
    int                  idx_i;
    logic [DIGITS-1:0]   sel_p0;
    logic [7:0]          data_p0;

    assign slot_end  = (cnt == CNT_W'(SCAN_CYCLES - 1));
    assign frame_end = slot_end && (idx == IDX_W'(DIGITS - 1));
    assign blank     = (cnt < CNT_W'(BLANK_CYCLES));

    // Slot timer and digit index
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            idx <= '0;
        end else begin
            cnt <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end) begin
                idx <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + 1'b1;
            end
        end
    end

    // Frame-synchronous snapshot of everything that affects the picture
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_data <= '0;
            snap_dp   <= '0;
            snap_en   <= '0;
            snap_hex  <= 1'b0;
            snap_lz   <= 1'b0;
        end else if (frame_end) begin
            snap_data <= bus.data_in;
            snap_dp   <= bus.dp_in;
            snap_en   <= bus.en_in;
            snap_hex  <= bus.hex_mode;
            snap_lz   <= bus.lz_suppress;
        end
    end

    // Select/segment pattern for the current slot, including leading-zero blanking
    always_comb begin
        idx_i    = int'(idx);
        nib      = snap_data[4*idx_i +: 4];
        all_zero = 1'b1;
        suppress = 1'b0;
        // Walk down from the MSD; a digit is a leading zero if it and all above are 0
        for (int i = DIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (snap_data[4*i +: 4] == 4'h0);
            if (i == idx_i) begin
                suppress = snap_lz & all_zero;
            end
        end
        sel_p0  = '1;
        data_p0 = 8'hFF;
        if (!blank) begin
            if (snap_en[idx]) begin
                sel_p0[idx] = 1'b0;
            end
            data_p0 = {~snap_dp[idx], suppress ? 7'h7F : decode_seg(nib, snap_hex)};
        end
    end

    // ---- output register stage ----
    // Registered pins and the one-cycle frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.seg_sel    <= '1;
            bus.seg_data   <= 8'hFF;
            bus.frame_done <= 1'b0;
        end else begin
            bus.seg_sel    <= sel_p0;
            bus.seg_data   <= data_p0;
            bus.frame_done <= frame_end;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a frame-position reference model predicts the
// pins every cycle under directed and randomized input changes.
module tb_seg7_scan_driver;
    localparam int DIGITS = 6;
    localparam int SC     = 8;
    localparam int BC     = 2;
    localparam int FRAME  = DIGITS * SC;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) bus ();

    seg7_scan_driver #(
        .DIGITS(DIGITS), .SCAN_CYCLES(SC), .BLANK_CYCLES(BC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Digit glyph table (g..a, active-low)
    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int last_fd = 0;

    // Reference model: position within frame plus the captured inputs
    int                  p;
    logic [4*DIGITS-1:0] m_data;
    logic [DIGITS-1:0]   m_dp, m_en;
    logic                m_hex, m_lz;
    logic [DIGITS-1:0]   exp_sel;
    logic [7:0]          exp_data;
    logic                exp_fd;
    logic                exp_dv;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // One clock: predict next outputs from the model at the edge, compare at negedge
    task automatic step();
        int slot, c;
        logic [3:0] nib;
        logic [6:0] glyph;
        logic supp;
        @(posedge clk);
        cyc++;
        if (rst) begin
            p = 0; m_data = '0; m_dp = '0; m_en = '0; m_hex = 1'b0; m_lz = 1'b0;
            exp_sel = '1; exp_data = 8'hFF; exp_fd = 1'b0; exp_dv = 1'b1;
            last_fd = cyc;
        end else begin
            slot = p / SC;
            c    = p % SC;
            exp_sel  = '1;
            exp_data = 8'hFF;
            exp_dv   = 1'b1;
            if (c >= BC) begin
                if (m_en[slot]) exp_sel[slot] = 1'b0;
                nib   = 4'(m_data >> (4 * slot));
                glyph = (nib > 4'd9 && !m_hex) ? 7'h7F : seg_tab[nib];
                supp  = m_lz && (slot > 0) && ((m_data >> (4 * slot)) == 0);
                exp_data = {~m_dp[slot], supp ? 7'h7F : glyph};
                exp_dv   = m_en[slot];
            end
            exp_fd = (p == FRAME - 1);
            if (p == FRAME - 1) begin
                m_data = bus.data_in; m_dp = bus.dp_in; m_en = bus.en_in;
                m_hex = bus.hex_mode; m_lz = bus.lz_suppress;
            end
            p = (p + 1) % FRAME;
        end
        @(negedge clk);
        check("seg_sel", 32'(bus.seg_sel), 32'(exp_sel));
        if (exp_dv) check("seg_data", 32'(bus.seg_data), 32'(exp_data));
        check("frame_done", 32'(bus.frame_done), 32'(exp_fd));
        if (bus.frame_done === 1'b1) begin
            check("fd_period", cyc - last_fd, FRAME);
            last_fd = cyc;
        end
    endtask

    // Advance until the current cycle sits at frame position tgt (outputs show tgt-1)
    task automatic run_to(input int tgt);
        for (int k = 0; k <= FRAME; k++) begin
            step();
            if (p == tgt) return;
        end
        check("run_to_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.data_in = '0; bus.dp_in = '0; bus.en_in = 6'h3F;
        bus.hex_mode = 1'b0; bus.lz_suppress = 1'b0;
        p = 0; m_data = '0; m_dp = '0; m_en = '0; m_hex = 1'b0; m_lz = 1'b0;

        // Reset held three cycles
        repeat (3) step();
        check("rst_sel", 32'(bus.seg_sel), 32'h3F);
        check("rst_data", 32'(bus.seg_data), 32'hFF);
        check("rst_fd", 32'(bus.frame_done), 0);
        rst = 1'b0;

        // Decode pattern loaded during the dark first frame
        bus.data_in = 24'h123456; bus.dp_in = 6'b000100; bus.en_in = 6'h3F;
        repeat (47) begin
            step();
            check("dark_sel", 32'(bus.seg_sel), 32'h3F);
        end
        step();
        check("first_fd", 32'(bus.frame_done), 1);
        run_to(6);
        check("dec_s0_sel", 32'(bus.seg_sel), 32'h3E);
        check("dec_s0_data", 32'(bus.seg_data), 32'h82);
        run_to(22);
        check("dec_s2_sel", 32'(bus.seg_sel), 32'h3B);
        check("dec_s2_data", 32'(bus.seg_data), 32'h19);

        // Hex letters versus blank
        bus.data_in = 24'h12345A; bus.dp_in = '0; bus.hex_mode = 1'b1;
        run_to(0); run_to(6);
        check("hex_a_data", 32'(bus.seg_data), 32'h88);
        bus.hex_mode = 1'b0;
        run_to(0); run_to(6);
        check("nohex_data", 32'(bus.seg_data), 32'hFF);
        check("nohex_sel", 32'(bus.seg_sel), 32'h3E);

        // Leading-zero suppression
        bus.data_in = 24'h000120; bus.lz_suppress = 1'b1;
        run_to(0);
        run_to(6);  check("lz_s0", 32'(bus.seg_data), 32'hC0);
        run_to(14); check("lz_s1", 32'(bus.seg_data), 32'hA4);
        run_to(22); check("lz_s2", 32'(bus.seg_data), 32'hF9);
        run_to(30); check("lz_s3", 32'(bus.seg_data), 32'hFF);
        run_to(38); check("lz_s4", 32'(bus.seg_data), 32'hFF);
        run_to(46); check("lz_s5", 32'(bus.seg_data), 32'hFF);
        bus.data_in = '0;
        run_to(0);
        run_to(6);  check("lz0_s0", 32'(bus.seg_data), 32'hC0);
        run_to(14); check("lz0_s1", 32'(bus.seg_data), 32'hFF);

        // Mid-frame change with digit 3 disabled: only the next frame reacts
        run_to(20);
        bus.data_in = 24'h987654; bus.en_in = 6'b110111; bus.lz_suppress = 1'b0;
        run_to(30); check("tear_s3_sel", 32'(bus.seg_sel), 32'h37);
        run_to(25);
        for (int k = 0; k < SC; k++) begin
            check("dis_s3_sel", 32'(bus.seg_sel), 32'h3F);
            step();
        end

        // Randomized input churn; the model checks every cycle
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(1, 30)) step();
            bus.data_in     = 24'($urandom) >> (4 * $urandom_range(0, 6));
            bus.dp_in       = 6'($urandom);
            bus.en_in       = 6'($urandom) | 6'($urandom);
            bus.hex_mode    = 1'($urandom);
            bus.lz_suppress = 1'($urandom);
        end

        // Reset mid-frame at digit 3, count 5
        run_to(0); run_to(29);
        rst = 1'b1;
        step();
        check("mid_rst_sel", 32'(bus.seg_sel), 32'h3F);
        check("mid_rst_data", 32'(bus.seg_data), 32'hFF);
        check("mid_rst_fd", 32'(bus.frame_done), 0);
        rst = 1'b0;
        repeat (47) step();
        step();
        check("fd_after_rst", 32'(bus.frame_done), 1);
        repeat (20) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
